// File: rtl/beat_sequencer.sv
// Song-position timebase: steps beat_cnt from 1 to BEATS at a tempo-selected rate,
// with start / pause / stop control and an end-of-song level.
module beat_sequencer #(
   parameter int BEATS    = 96,
   parameter int DIV_SLOW = 18_750_000,
   parameter int DIV_NORM = 12_500_000,
   parameter int DIV_FAST = 6_250_000,
   parameter int DIV_W    = 25
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       pause,
   input  logic       stop,
   input  logic [1:0] tempo_sel,
   output logic [6:0] beat_cnt,
   output logic       beat_tick,
   output logic       playing,
   output logic       paused,
   output logic       song_done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [6:0]       LAST_BEAT = 7'(BEATS);
   localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);

   state_t           state_q, state_d;
   logic [DIV_W-1:0] presc_q, presc_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [6:0]       beat_q, beat_d;
   logic             tick_q, tick_d;
   logic             playing_q, playing_d;
   logic             paused_q, paused_d;
   logic             done_q, done_d;
   logic             start_q, pause_q;

   logic             start_ev, pause_ev;
   logic [DIV_W-1:0] sel_div;

   assign start_ev = start & ~start_q;
   assign pause_ev = pause & ~pause_q;

   // Beat period requested by the tempo switch; only sampled when a song starts.
   always_comb begin
      sel_div = DIV_W'(DIV_NORM);
      case (tempo_sel)
         2'd0:    sel_div = DIV_W'(DIV_SLOW);
         2'd2:    sel_div = DIV_W'(DIV_FAST);
         default: sel_div = DIV_W'(DIV_NORM);
      endcase
   end

   // Next-state, prescaler and beat counter; stop overrides every other event.
   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      div_d   = div_q;
      beat_d  = beat_q;
      tick_d  = 1'b0;

      if (stop) begin
         state_d = ST_IDLE;
         beat_d  = 7'd0;
         presc_d = '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start_ev) begin
                  state_d = ST_PLAY;
                  div_d   = sel_div;
                  beat_d  = 7'd1;
                  tick_d  = 1'b1;
                  presc_d = '0;
               end
            end
            ST_PLAY: begin
               if (presc_q == div_q - DIV_ONE) begin
                  presc_d = '0;
                  if (beat_q < LAST_BEAT) begin
                     beat_d = beat_q + 7'd1;
                     tick_d = 1'b1;
                  end else begin
                     state_d = ST_DONE;
                     beat_d  = 7'd0;
                  end
               end else begin
                  presc_d = presc_q + DIV_ONE;
               end
               // The step above is taken first; a pause on the final step is dropped.
               if (pause_ev && state_d == ST_PLAY) begin
                  state_d = ST_PAUSE;
               end
            end
            ST_PAUSE: begin
               if (start_ev) begin
                  state_d = ST_PLAY;
                  div_d   = sel_div;
                  beat_d  = 7'd1;
                  tick_d  = 1'b1;
                  presc_d = '0;
               end else if (pause_ev) begin
                  state_d = ST_PLAY;
               end
            end
            default: begin
               state_d = ST_IDLE;
               beat_d  = 7'd0;
               presc_d = '0;
            end
         endcase
      end

      playing_d = (state_d == ST_PLAY);
      paused_d  = (state_d == ST_PAUSE);
      done_d    = (state_d == ST_DONE);
   end

   // State, counters, edge-detect copies and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         presc_q   <= '0;
         div_q     <= '0;
         beat_q    <= 7'd0;
         tick_q    <= 1'b0;
         playing_q <= 1'b0;
         paused_q  <= 1'b0;
         done_q    <= 1'b0;
         start_q   <= 1'b0;
         pause_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         div_q     <= div_d;
         beat_q    <= beat_d;
         tick_q    <= tick_d;
         playing_q <= playing_d;
         paused_q  <= paused_d;
         done_q    <= done_d;
         start_q   <= start;
         pause_q   <= pause;
      end
   end

   assign beat_cnt  = beat_q;
   assign beat_tick = tick_q;
   assign playing   = playing_q;
   assign paused    = paused_q;
   assign song_done = done_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// Self-checking bench for beat_sequencer with shortened tempo dividers.
module tb_beat_sequencer;

   localparam int BEATS = 96;

   logic       clk = 1'b0;
   logic       rst, start, pause, stop;
   logic [1:0] tempo_sel;
   logic [6:0] beat_cnt;
   logic       beat_tick, playing, paused, song_done;

   beat_sequencer #(
      .BEATS(BEATS), .DIV_SLOW(6), .DIV_NORM(4), .DIV_FAST(2), .DIV_W(25)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop),
      .tempo_sel(tempo_sel), .beat_cnt(beat_cnt), .beat_tick(beat_tick),
      .playing(playing), .paused(paused), .song_done(song_done)
   );

   always #5 clk = ~clk;

   // Expected tick: beat value and the edge number on which it must appear.
   typedef struct {
      int beat;
      int cyc;
   } tick_exp_t;

   typedef struct {
      logic [1:0] sel;
      logic [1:0] sel_mid;
      int         div;
   } tempo_vec_t;

   tick_exp_t sb[$];
   int        cyc = 0;
   int        n_total = 0;
   int        n_pass = 0;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // Advance one edge and compare the tick stream against the scoreboard.
   task automatic tick_clk();
      tick_exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         check($sformatf("tick_present_beat%0d", e.beat), int'(beat_tick), 1);
         check($sformatf("tick_beat_value_%0d", e.beat), int'(beat_cnt), e.beat);
      end else begin
         check("no_stray_tick", int'(beat_tick), 0);
      end
      if (!playing && !paused) check("beat_zero_when_stopped", int'(beat_cnt), 0);
   endtask

   task automatic run_until(input int target);
      while (cyc < target) tick_clk();
   endtask

   // Queue ticks for beats first..last, beat 1 of the song being on edge t1.
   task automatic push_song(input int t1, input int div, input int first, input int last);
      tick_exp_t e;
      for (int k = first; k <= last; k++) begin
         e.beat = k;
         e.cyc  = t1 + (k - 1) * div;
         sb.push_back(e);
      end
   endtask

   task automatic stop_pulse();
      stop = 1'b1;
      tick_clk();
      stop = 1'b0;
      check("stop_beat_zero", int'(beat_cnt), 0);
      check("stop_not_playing", int'(playing), 0);
   endtask

   task automatic restart_check(input string name);
      tick_exp_t e;
      e.beat = 1;
      e.cyc  = cyc + 1;
      sb.push_back(e);
      start = 1'b1;
      tick_clk();
      start = 1'b0;
      check(name, int'(playing), 1);
   endtask

   tempo_vec_t vecs[4];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int t1, e_pause, r_edge;
      tick_exp_t e;

      vecs[0] = '{sel: 2'd1, sel_mid: 2'd1, div: 4};
      vecs[1] = '{sel: 2'd2, sel_mid: 2'd0, div: 2};
      vecs[2] = '{sel: 2'd0, sel_mid: 2'd2, div: 6};
      vecs[3] = '{sel: 2'd3, sel_mid: 2'd2, div: 4};

      rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; tempo_sel = 2'd1;
      #1;
      tick_clk();
      tick_clk();
      check("rst_beat_cnt", int'(beat_cnt), 0);
      check("rst_beat_tick", int'(beat_tick), 0);
      check("rst_playing", int'(playing), 0);
      check("rst_paused", int'(paused), 0);
      check("rst_song_done", int'(song_done), 0);
      rst = 1'b0;
      tick_clk();

      // Full songs at each tempo; the tempo switch moves mid-song without effect.
      for (int v = 0; v < 4; v++) begin
         tempo_sel = vecs[v].sel;
         t1 = cyc + 1;
         push_song(t1, vecs[v].div, 1, BEATS);
         start = 1'b1;
         tick_clk();
         start = 1'b0;
         run_until(t1 + 48 * vecs[v].div);
         tempo_sel = vecs[v].sel_mid;
         run_until(t1 + 95 * vecs[v].div);
         check($sformatf("v%0d_last_beat", v), int'(beat_cnt), BEATS);
         check($sformatf("v%0d_not_done_yet", v), int'(song_done), 0);
         run_until(t1 + 96 * vecs[v].div);
         check($sformatf("v%0d_song_done", v), int'(song_done), 1);
         check($sformatf("v%0d_done_beat_zero", v), int'(beat_cnt), 0);
         check($sformatf("v%0d_done_not_playing", v), int'(playing), 0);
         check($sformatf("v%0d_all_ticks_seen", v), sb.size(), 0);
         stop_pulse();
         check($sformatf("v%0d_stop_clears_done", v), int'(song_done), 0);
      end

      // Pause at beat 10 with prescaler at 2, hold 50 cycles, then resume.
      tempo_sel = 2'd1;
      t1 = cyc + 1;
      push_song(t1, 4, 1, 10);
      start = 1'b1;
      tick_clk();
      start = 1'b0;
      e_pause = t1 + 9 * 4;
      run_until(e_pause + 2);
      pause = 1'b1;
      tick_clk();
      check("pause_paused", int'(paused), 1);
      check("pause_not_playing", int'(playing), 0);
      check("pause_beat10", int'(beat_cnt), 10);
      repeat (49) tick_clk();
      check("pause_hold_beat10", int'(beat_cnt), 10);
      check("pause_hold_paused", int'(paused), 1);
      pause = 1'b0;
      tick_clk();
      check("pause_release_still_paused", int'(paused), 1);
      pause = 1'b1;
      r_edge = cyc + 1;
      e.beat = 11; e.cyc = r_edge + 1; sb.push_back(e);
      e.beat = 12; e.cyc = r_edge + 5; sb.push_back(e);
      tick_clk();
      check("resume_playing", int'(playing), 1);
      check("resume_beat10", int'(beat_cnt), 10);
      run_until(r_edge + 5);
      pause = 1'b0;
      stop_pulse();

      // Stop together with a pause edge at beat 40.
      t1 = cyc + 1;
      push_song(t1, 4, 1, 40);
      start = 1'b1;
      tick_clk();
      start = 1'b0;
      run_until(t1 + 39 * 4);
      stop = 1'b1;
      pause = 1'b1;
      tick_clk();
      stop = 1'b0;
      pause = 1'b0;
      check("stoppause_beat0", int'(beat_cnt), 0);
      check("stoppause_paused", int'(paused), 0);
      check("stoppause_playing", int'(playing), 0);
      repeat (5) tick_clk();
      restart_check("stoppause_restart");
      stop_pulse();

      // Start held 20 cycles, a second press mid-song, then a restart from DONE.
      tempo_sel = 2'd2;
      t1 = cyc + 1;
      push_song(t1, 2, 1, BEATS);
      start = 1'b1;
      repeat (20) tick_clk();
      start = 1'b0;
      run_until(t1 + 30);
      start = 1'b1;
      tick_clk();
      start = 1'b0;
      run_until(t1 + 96 * 2);
      check("held_song_done", int'(song_done), 1);
      check("held_all_ticks_seen", sb.size(), 0);
      restart_check("done_restart");
      check("done_restart_clears_done", int'(song_done), 0);
      stop_pulse();

      // Reset pulse at beat 55.
      t1 = cyc + 1;
      push_song(t1, 2, 1, 55);
      start = 1'b1;
      tick_clk();
      start = 1'b0;
      run_until(t1 + 54 * 2);
      rst = 1'b1;
      tick_clk();
      rst = 1'b0;
      check("midrst_beat_cnt", int'(beat_cnt), 0);
      check("midrst_beat_tick", int'(beat_tick), 0);
      check("midrst_playing", int'(playing), 0);
      check("midrst_paused", int'(paused), 0);
      check("midrst_song_done", int'(song_done), 0);
      tick_clk();
      restart_check("midrst_restart");
      stop_pulse();

      check("scoreboard_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
